rcon_gen: RTL and testbench

RCON_GEN -- requirements
Module: rcon_gen

---
 rtl/rcon_gen.sv | 158 +++++++++++++++
 tb/tb_rcon_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rcon_gen.sv
// AES key-schedule round-constant generator: IDLE/RUN/DONE sequencer with a valid/ready handshake.
// Optional reverse schedule (dir port) is built only when RCON_GEN_INV_EN is defined.
module rcon_gen #(
    parameter int OUT_W     = 32,
    parameter int BYTE_LANE = OUT_W/8-1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
`ifdef RCON_GEN_INV_EN
    input  logic             dir,
`endif
    output logic [OUT_W-1:0] rcon,
    output logic [3:0]       index,
    output logic             valid,
    input  logic             ready,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_mode;
    logic [7:0]  r_byte;
    logic [3:0]  r_index;
    logic        r_valid;
    logic        r_done;
    logic        r_err;
`ifdef RCON_GEN_INV_EN
    logic        r_dir;
`endif

    logic        w_start_ok;
    logic        w_start_bad;
    logic        w_hs;
    logic        w_fin;
    logic [3:0]  w_last;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [3:0] last_of(input logic [1:0] m);
        case (m)
            2'b00:   return 4'd10;
            2'b01:   return 4'd8;
            default: return 4'd7;
        endcase
    endfunction

`ifdef RCON_GEN_INV_EN
    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        return b[0] ? (((b ^ 8'h1B) >> 1) | 8'h80) : (b >> 1);
    endfunction

    function automatic logic [7:0] last_const(input logic [1:0] m);
        case (m)
            2'b00:   return 8'h36;
            2'b01:   return 8'h80;
            default: return 8'h40;
        endcase
    endfunction
`endif

    assign w_start_ok  = start && (mode != 2'b11);
    assign w_start_bad = start && (mode == 2'b11);
    assign w_hs        = r_valid && ready;
    assign w_last      = last_of(r_mode);

`ifdef RCON_GEN_INV_EN
    assign w_fin = r_dir ? (r_index == 4'd1) : (r_index == w_last);
`else
    assign w_fin = (r_index == w_last);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_mode  <= '0;
            r_byte  <= '0;
            r_index <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef RCON_GEN_INV_EN
            r_dir   <= 1'b0;
`endif
        end else begin
            r_err  <= w_start_bad;
            r_done <= 1'b0;
            // A legal start wins over everything, including a handshake in RUN.
            if (w_start_ok) begin
                r_state <= RUN;
                r_mode  <= mode;
                r_valid <= 1'b1;
`ifdef RCON_GEN_INV_EN
                r_dir   <= dir;
                if (dir) begin
                    r_byte  <= last_const(mode);
                    r_index <= last_of(mode);
                end else begin
                    r_byte  <= 8'h01;
                    r_index <= 4'd1;
                end
`else
                r_byte  <= 8'h01;
                r_index <= 4'd1;
`endif
            end else begin
                case (r_state)
                    RUN: begin
                        if (w_hs) begin
                            if (w_fin) begin
                                r_state <= DONE;
                                r_valid <= 1'b0;
                                r_done  <= 1'b1;
                                r_byte  <= '0;
                                r_index <= '0;
                            end else begin
`ifdef RCON_GEN_INV_EN
                                if (r_dir) begin
                                    r_byte  <= inv_xtime(r_byte);
                                    r_index <= r_index - 4'd1;
                                end else begin
                                    r_byte  <= xtime(r_byte);
                                    r_index <= r_index + 4'd1;
                                end
`else
                                r_byte  <= xtime(r_byte);
                                r_index <= r_index + 4'd1;
`endif
                            end
                        end
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        rcon = '0;
        rcon[8*BYTE_LANE +: 8] = r_byte;
    end

    assign index = r_index;
    assign valid = r_valid;
    assign done  = r_done;
    assign err   = r_err;

endmodule

// File: tb/tb_rcon_gen.sv
// Directed self-checking bench for rcon_gen (default 32-bit word, constant in the top lane).
// Reverse-schedule vectors run only when RCON_GEN_INV_EN is defined.
module tb_rcon_gen;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic        ready;
    logic [31:0] rcon;
    logic [3:0]  index;
    logic        valid;
    logic        done;
    logic        err;
`ifdef RCON_GEN_INV_EN
    logic        dir;
`endif

    int n_checks;
    int n_errors;

    logic [7:0] fwd_tab [10];

    rcon_gen #(
        .OUT_W     (32),
        .BYTE_LANE (3)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
`ifdef RCON_GEN_INV_EN
        .dir   (dir),
`endif
        .rcon  (rcon),
        .index (index),
        .valid (valid),
        .ready (ready),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs while a constant is presented.
    task automatic expect_run(input string tag, input logic [7:0] b, input logic [3:0] idx);
        check({tag, ".rcon"},  64'(rcon),  64'({b, 24'h0}));
        check({tag, ".index"}, 64'(index), 64'(idx));
        check({tag, ".valid"}, 64'(valid), 64'd1);
        check({tag, ".done"},  64'(done),  64'd0);
    endtask

    task automatic expect_idle(input string tag, input logic exp_done);
        check({tag, ".rcon"},  64'(rcon),  64'd0);
        check({tag, ".index"}, 64'(index), 64'd0);
        check({tag, ".valid"}, 64'(valid), 64'd0);
        check({tag, ".done"},  64'(done),  64'(exp_done));
    endtask

    // Pulse start for one cycle; mode is then scrambled to show it was latched.
    task automatic do_start(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
        mode  = 2'b11;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        fwd_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 2'b00;
        ready = 1'b1;
`ifdef RCON_GEN_INV_EN
        dir   = 1'b0;
`endif

        // Reset state
        tick();
        tick();
        expect_idle("reset", 1'b0);
        check("reset.err", 64'(err), 64'd0);
        rst_n = 1'b1;
        tick();
        expect_idle("post_reset", 1'b0);

        // AES-128 forward, ready held high: one constant per cycle
        do_start(2'b00);
        for (int i = 0; i < 10; i++) begin
            expect_run($sformatf("aes128[%0d]", i + 1), fwd_tab[i], 4'(i + 1));
            tick();
        end
        expect_idle("aes128.done", 1'b1);
        tick();
        expect_idle("aes128.after", 1'b0);

        // AES-256 with ready toggling: values hold while ready=0
        do_start(2'b10);
        for (int i = 0; i < 7; i++) begin
            expect_run($sformatf("aes256[%0d]", i + 1), fwd_tab[i], 4'(i + 1));
            ready = 1'b0;
            tick();
            expect_run($sformatf("aes256_hold[%0d]", i + 1), fwd_tab[i], 4'(i + 1));
            ready = 1'b1;
            tick();
        end
        expect_idle("aes256.done", 1'b1);
        tick();
        expect_idle("aes256.after", 1'b0);

        // AES-192 ends at 0x80
        do_start(2'b01);
        for (int i = 0; i < 8; i++) begin
            expect_run($sformatf("aes192[%0d]", i + 1), fwd_tab[i], 4'(i + 1));
            tick();
        end
        expect_idle("aes192.done", 1'b1);
        tick();

        // Restart at index 4 with a simultaneous handshake
        do_start(2'b00);
        tick();
        tick();
        tick();
        expect_run("restart.before", 8'h08, 4'd4);
        do_start(2'b00);
        expect_run("restart.after", 8'h01, 4'd1);
        tick();
        expect_run("restart.next", 8'h02, 4'd2);
        tick();
        tick();
        tick();
        expect_run("abort.before", 8'h10, 4'd5);

        // Asynchronous reset mid-run
        rst_n = 1'b0;
        #1;
        expect_idle("abort.async", 1'b0);
        tick();
        expect_idle("abort.held", 1'b0);
        rst_n = 1'b1;
        tick();
        expect_idle("abort.release", 1'b0);

        // Reserved mode: err pulse, no run
        start = 1'b1;
        mode  = 2'b11;
        tick();
        start = 1'b0;
        mode  = 2'b00;
        check("bad_mode.err", 64'(err), 64'd1);
        check("bad_mode.valid", 64'(valid), 64'd0);
        tick();
        check("bad_mode.err_clear", 64'(err), 64'd0);
        expect_idle("bad_mode.idle", 1'b0);

`ifdef RCON_GEN_INV_EN
        // Reverse AES-128 schedule
        dir = 1'b1;
        do_start(2'b00);
        dir = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            expect_run($sformatf("rev128[%0d]", i + 1), fwd_tab[i], 4'(i + 1));
            tick();
        end
        expect_idle("rev128.done", 1'b1);
        tick();
        expect_idle("rev128.after", 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
